accum_sample_buffer: RTL and testbench

//   Downstream stage of the 8-bit accumulator: captures {sum, carry, overflow} snapshots on a sample

---
 rtl/accum_sample_buffer_pkg.sv | 20 ++
 rtl/accum_sample_buffer_if.sv | 13 +
 rtl/accum_fifo_ctrl.sv | 67 ++++++
 rtl/accum_sample_buffer.sv | 103 ++++++++++
 tb/tb_accum_sample_buffer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/accum_sample_buffer_pkg.sv
// Shared definitions for the accumulator sample buffer: default widths, entry layout and FIFO op encoding.
package accum_sample_buffer_pkg;

  localparam int ACC_W      = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int DROP_W_DEF = 8;

  // Entry layout {v, c, sum}; offsets are relative to the captured sum width.
  localparam int SUM_LSB = 0;
  localparam int C_REL   = 0;
  localparam int V_REL   = 1;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/accum_sample_buffer_if.sv
// Read-side valid/ready handshake carrying the head snapshot {sum, carry, overflow}.
interface accum_sample_buffer_if #(
  parameter int DATA_W = 8
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_c;
  logic              rd_v;

  modport master (output rd_valid, output rd_data, output rd_c, output rd_v, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_c, input rd_v, output rd_ready);
endinterface

// File: rtl/accum_fifo_ctrl.sv
// FIFO bookkeeping: push/pop qualification, wrapping pointers and occupancy count.
module accum_fifo_ctrl
  import accum_sample_buffer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample,
  input  logic              rd_ready,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  fifo_op_e          op;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign pop  = !empty && rd_ready;
  assign push = sample && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    op       = fifo_op_e'({push, pop});
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case (op)
      OP_PUSH: count_d = count_q + CNT_ONE;
      OP_POP:  count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/accum_sample_buffer.sv
// Captures accumulator {sum, carry, overflow} snapshots into a FWFT FIFO with sticky flags
// and a saturating dropped-sample counter.
module accum_sample_buffer
  import accum_sample_buffer_pkg::*;
#(
  parameter int DATA_W = ACC_W,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     sum_in,
  input  logic                  c_in,
  input  logic                  v_in,
  input  logic                  sample,
  input  logic                  clear_sticky,
  accum_sample_buffer_if.master rd_if,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty,
  output logic                  sticky_c,
  output logic                  sticky_v,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int C_BIT   = DATA_W + C_REL;
  localparam int V_BIT   = DATA_W + V_REL;
  localparam int ENTRY_W = DATA_W + 2;
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic              push, pop;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [ENTRY_W-1:0] entry_in, head;
  logic               sticky_c_q, sticky_c_d;
  logic               sticky_v_q, sticky_v_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  accum_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .sample   (sample),
    .rd_ready (rd_if.rd_ready),
    .push     (push),
    .pop      (pop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    entry_in = '0;
    entry_in[SUM_LSB +: DATA_W] = sum_in;
    entry_in[C_BIT]             = c_in;
    entry_in[V_BIT]             = v_in;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = entry_in;
  end

  // Storage has no reset; empty gating below hides stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    // A setting sample overrides a same-cycle clear.
    sticky_c_d = (clear_sticky ? 1'b0 : sticky_c_q) | (sample & c_in);
    sticky_v_d = (clear_sticky ? 1'b0 : sticky_v_q) | (sample & v_in);
    drop_d     = drop_q;
    if (sample && full && !pop && (drop_q != '1)) drop_d = drop_q + DROP_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_c_q <= 1'b0;
      sticky_v_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      sticky_c_q <= sticky_c_d;
      sticky_v_q <= sticky_v_d;
      drop_q     <= drop_d;
    end
  end

  assign head           = empty ? '0 : mem_q[rd_ptr];
  assign rd_if.rd_valid = !empty;
  assign rd_if.rd_data  = head[SUM_LSB +: DATA_W];
  assign rd_if.rd_c     = head[C_BIT];
  assign rd_if.rd_v     = head[V_BIT];

  assign sticky_c = sticky_c_q;
  assign sticky_v = sticky_v_q;
  assign drop_cnt = drop_q;

  logic unused_pop;
  assign unused_pop = pop;

endmodule

// File: tb/tb_accum_sample_buffer.sv
// Directed self-checking bench for accum_sample_buffer with hand-computed expectations.
module tb_accum_sample_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sum_in;
  logic       c_in, v_in, sample, clear_sticky;
  logic [3:0] count;
  logic       full, empty, sticky_c, sticky_v;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  accum_sample_buffer_if #(.DATA_W(8)) rd_if ();

  accum_sample_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .sum_in       (sum_in),
    .c_in         (c_in),
    .v_in         (v_in),
    .sample       (sample),
    .clear_sticky (clear_sticky),
    .rd_if        (rd_if),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .sticky_c     (sticky_c),
    .sticky_v     (sticky_v),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] drain_exp [8];
    reset = 1'b1; sum_in = '0; c_in = 0; v_in = 0; sample = 0; clear_sticky = 0;
    rd_if.rd_ready = 0;
    repeat (2) tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", rd_if.rd_valid, 0);
    chk("rst_data", rd_if.rd_data, 8'h00);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    tick();

    // single capture with FWFT latency of one edge
    sum_in = 8'h5A; c_in = 1; v_in = 0; sample = 1;
    tick();
    sample = 0; c_in = 0;
    chk("cap_valid", rd_if.rd_valid, 1);
    chk("cap_data", rd_if.rd_data, 8'h5A);
    chk("cap_c", rd_if.rd_c, 1);
    chk("cap_v", rd_if.rd_v, 0);
    chk("cap_sticky_c", sticky_c, 1);
    chk("cap_sticky_v", sticky_v, 0);
    chk("cap_count", count, 1);
    rd_if.rd_ready = 1;
    tick();
    rd_if.rd_ready = 0;
    chk("cap_drained_empty", empty, 1);
    chk("cap_drained_data", rd_if.rd_data, 8'h00);
    chk("cap_drained_c", rd_if.rd_c, 0);

    // empty + rd_ready: no pop, nothing underflows
    rd_if.rd_ready = 1;
    tick();
    chk("empty_pop_count", count, 0);
    // empty + sample + rd_ready: push only
    sum_in = 8'h44; sample = 1;
    tick();
    sample = 0; rd_if.rd_ready = 0;
    chk("empty_push_rdy_count", count, 1);
    chk("empty_push_rdy_data", rd_if.rd_data, 8'h44);
    rd_if.rd_ready = 1;
    tick();
    rd_if.rd_ready = 0;

    // sticky clear, then set-wins-over-clear
    clear_sticky = 1;
    tick();
    chk("clr_sticky_c", sticky_c, 0);
    sum_in = 8'h33; v_in = 1; sample = 1;
    tick();
    sample = 0; v_in = 0;
    chk("setwin_sticky_v", sticky_v, 1);
    chk("setwin_sticky_c", sticky_c, 0);
    chk("setwin_rd_v", rd_if.rd_v, 1);
    tick();
    clear_sticky = 0;
    chk("clr_alone_sticky_v", sticky_v, 0);
    rd_if.rd_ready = 1;
    tick();
    rd_if.rd_ready = 0;
    chk("sticky_drain_empty", empty, 1);

    // fill with 10 samples: 8 stored, 2 dropped
    for (int i = 1; i <= 10; i++) begin
      sum_in = 8'(i); sample = 1;
      tick();
    end
    sample = 0;
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_drop", drop_cnt, 2);
    chk("fill_head", rd_if.rd_data, 8'h01);

    // full + sample + pop: both happen, no drop
    sum_in = 8'hFF; sample = 1; rd_if.rd_ready = 1;
    tick();
    sample = 0;
    chk("fullpop_count", count, 8);
    chk("fullpop_drop", drop_cnt, 2);
    chk("fullpop_full", full, 1);
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), rd_if.rd_data, drain_exp[i]);
      tick();
    end
    rd_if.rd_ready = 0;
    chk("drain_empty", empty, 1);
    chk("drain_valid", rd_if.rd_valid, 0);

    // drop counter saturation; carry set so reset can be seen clearing it
    c_in = 1;
    for (int i = 0; i < 8; i++) begin
      sum_in = 8'h80 + 8'(i); sample = 1;
      tick();
    end
    chk("sat_fill_drop", drop_cnt, 2);
    repeat (252) tick();
    chk("sat_fe", drop_cnt, 8'hFE);
    repeat (48) tick();
    sample = 0; c_in = 0;
    chk("sat_ff", drop_cnt, 8'hFF);
    chk("sat_head", rd_if.rd_data, 8'h80);
    chk("sat_head_c", rd_if.rd_c, 1);

    // leave 3 entries, then reset asynchronously mid-cycle
    rd_if.rd_ready = 1;
    repeat (5) tick();
    rd_if.rd_ready = 0;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_head", rd_if.rd_data, 8'h85);
    chk("pre_rst_sticky_c", sticky_c, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_valid", rd_if.rd_valid, 0);
    chk("arst_sticky_c", sticky_c, 0);
    chk("arst_sticky_v", sticky_v, 0);
    chk("arst_drop", drop_cnt, 0);
    tick();
    reset = 1'b0;
    tick();
    sum_in = 8'h77; sample = 1;
    tick();
    sample = 0;
    chk("post_rst_count", count, 1);
    chk("post_rst_data", rd_if.rd_data, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
